// File: rtl/dmem_port_arbiter.sv
// Shares the data_mem port between the CPU memory stage and a req/ack host with bounded host wait.
// Optional performance counters are enabled by defining ARB_PERF_EN.
module dmem_port_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cpu_memwrite,
    input  logic        i_cpu_memread,
    input  logic [31:0] i_cpu_adr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [2:0]  i_cpu_funct3,
    output logic        o_cpu_stall,
    input  logic        i_host_req,
    input  logic        i_host_we,
    input  logic [31:0] i_host_adr,
    input  logic [31:0] i_host_wdata,
    output logic        o_host_ack,
    output logic [31:0] o_host_rdata,
    output logic        o_mem_we,
    output logic [2:0]  o_mem_store,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
`ifdef ARB_PERF_EN
    ,
    output logic [15:0] o_perf_host_grants,
    output logic [15:0] o_perf_cpu_stalls
`endif
);

    typedef enum logic [1:0] {IDLE, HOST_ACC, ACK} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_host_ack;
    logic [31:0]       r_host_rdata;
    logic              w_cpu_access;
    logic              w_cpu_wins;
    logic              w_host_grant;

    assign w_cpu_access = i_cpu_memwrite | i_cpu_memread;

    // The CPU keeps the port while it is busy and the host has not yet waited MAX_WAIT cycles.
    assign w_cpu_wins   = w_cpu_access && (r_wait_cnt < WAIT_W'(MAX_WAIT));
    assign w_host_grant = (r_state == HOST_ACC) && i_host_req && !w_cpu_wins;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:     if (i_host_req) w_next_state = HOST_ACC;
            HOST_ACC: begin
                if (!i_host_req)       w_next_state = IDLE;
                else if (w_host_grant) w_next_state = ACK;
            end
            ACK:      w_next_state = IDLE;
            default:  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_mem_we    = i_cpu_memwrite;
        o_mem_store = i_cpu_funct3;
        o_mem_adr   = i_cpu_adr;
        o_mem_wdata = i_cpu_wdata;
        o_cpu_stall = 1'b0;
        if (w_host_grant) begin
            o_mem_we    = i_host_we;
            o_mem_store = 3'b010;
            o_mem_adr   = i_host_adr;
            o_mem_wdata = i_host_wdata;
            o_cpu_stall = w_cpu_access;
        end
    end

    // Wait counter only advances on cycles the CPU wins, so it stops at MAX_WAIT by construction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wait_cnt   <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 32'h0;
        end else begin
            r_host_ack <= w_host_grant;
            if (r_state == IDLE && i_host_req) begin
                r_wait_cnt <= '0;
            end else if (r_state == HOST_ACC && i_host_req && w_cpu_wins) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_host_grant) begin
                r_host_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_host_ack   = r_host_ack;
    assign o_host_rdata = r_host_rdata;

`ifdef ARB_PERF_EN
    logic [15:0] r_perf_host_grants;
    logic [15:0] r_perf_cpu_stalls;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_host_grants <= 16'h0;
            r_perf_cpu_stalls  <= 16'h0;
        end else begin
            if (w_host_grant && r_perf_host_grants != 16'hFFFF) begin
                r_perf_host_grants <= r_perf_host_grants + 16'h1;
            end
            if (o_cpu_stall && r_perf_cpu_stalls != 16'hFFFF) begin
                r_perf_cpu_stalls <= r_perf_cpu_stalls + 16'h1;
            end
        end
    end

    assign o_perf_host_grants = r_perf_host_grants;
    assign o_perf_cpu_stalls  = r_perf_cpu_stalls;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (MAX_WAIT=8); perf ports checked when ARB_PERF_EN is defined.
module tb_dmem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cpu_memwrite;
    logic        i_cpu_memread;
    logic [31:0] i_cpu_adr;
    logic [31:0] i_cpu_wdata;
    logic [2:0]  i_cpu_funct3;
    logic        o_cpu_stall;
    logic        i_host_req;
    logic        i_host_we;
    logic [31:0] i_host_adr;
    logic [31:0] i_host_wdata;
    logic        o_host_ack;
    logic [31:0] o_host_rdata;
    logic        o_mem_we;
    logic [2:0]  o_mem_store;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_wdata;
    logic [31:0] w_mem_rdata;
`ifdef ARB_PERF_EN
    logic [15:0] o_perf_host_grants;
    logic [15:0] o_perf_cpu_stalls;
`endif

    int assertCount = 0;
    int failCount   = 0;

    always #5 i_clk = ~i_clk;

    // Tiny memory model: one known word at 0x80, everything else derived from the address.
    assign w_mem_rdata = (o_mem_adr == 32'h80) ? 32'h12345678 : (o_mem_adr ^ 32'hA5A50000);

    dmem_port_arbiter #(.MAX_WAIT(8), .WAIT_W(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_cpu_memwrite(i_cpu_memwrite), .i_cpu_memread(i_cpu_memread),
        .i_cpu_adr(i_cpu_adr), .i_cpu_wdata(i_cpu_wdata), .i_cpu_funct3(i_cpu_funct3),
        .o_cpu_stall(o_cpu_stall),
        .i_host_req(i_host_req), .i_host_we(i_host_we), .i_host_adr(i_host_adr),
        .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_rdata(o_host_rdata),
        .o_mem_we(o_mem_we), .o_mem_store(o_mem_store), .o_mem_adr(o_mem_adr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(w_mem_rdata)
`ifdef ARB_PERF_EN
        , .o_perf_host_grants(o_perf_host_grants), .o_perf_cpu_stalls(o_perf_cpu_stalls)
`endif
    );

    task automatic nextCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic cpuWr, input logic cpuRd, input logic [31:0] cpuAdr,
                                 input logic hostReq, input logic hostWe, input logic [31:0] hostAdr,
                                 input logic [31:0] hostWdata);
        i_cpu_memwrite = cpuWr;
        i_cpu_memread  = cpuRd;
        i_cpu_adr      = cpuAdr;
        i_host_req     = hostReq;
        i_host_we      = hostWe;
        i_host_adr     = hostAdr;
        i_host_wdata   = hostWdata;
        #1;
    endtask

    initial begin
        i_reset = 1'b1;
        i_cpu_wdata  = 32'h00000011;
        i_cpu_funct3 = 3'b010;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();
        nextCycle();
        i_reset = 1'b0;

        // Reset state and CPU pass-through
        i_cpu_wdata  = 32'h00000055;
        i_cpu_funct3 = 3'b000;
        applyStimulus(1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rst_ack",      32'(o_host_ack),   32'h0);
        checkOutput("rst_rdata",    o_host_rdata,      32'h0);
        checkOutput("rst_stall",    32'(o_cpu_stall),  32'h0);
        checkOutput("pass_we",      32'(o_mem_we),     32'h1);
        checkOutput("pass_store",   32'(o_mem_store),  32'h0);
        checkOutput("pass_adr",     o_mem_adr,         32'h100);
        checkOutput("pass_wdata",   o_mem_wdata,       32'h55);
`ifdef ARB_PERF_EN
        checkOutput("rst_perf_g",   32'(o_perf_host_grants), 32'h0);
        checkOutput("rst_perf_s",   32'(o_perf_cpu_stalls),  32'h0);
`endif
        i_cpu_wdata  = 32'h00000011;
        i_cpu_funct3 = 3'b010;

        // Uncontended write
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        checkOutput("w_idle_we",    32'(o_mem_we),     32'h0);
        nextCycle();
        checkOutput("w_acc_we",     32'(o_mem_we),     32'h1);
        checkOutput("w_acc_store",  32'(o_mem_store),  32'h2);
        checkOutput("w_acc_adr",    o_mem_adr,         32'h40);
        checkOutput("w_acc_wdata",  o_mem_wdata,       32'hDEADBEEF);
        checkOutput("w_acc_stall",  32'(o_cpu_stall),  32'h0);
        checkOutput("w_acc_ack",    32'(o_host_ack),   32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
        checkOutput("w_ack",        32'(o_host_ack),   32'h1);
        checkOutput("w_ack_rdata",  o_host_rdata,      32'hA5A50040);
        checkOutput("w_ack_we",     32'(o_mem_we),     32'h0);
        checkOutput("w_ack_stall",  32'(o_cpu_stall),  32'h0);
        nextCycle();
        checkOutput("w_after_ack",  32'(o_host_ack),   32'h0);

        // Uncontended read
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h80, 32'h0);
        nextCycle();
        checkOutput("r_acc_we",     32'(o_mem_we),     32'h0);
        checkOutput("r_acc_adr",    o_mem_adr,         32'h80);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h200, 1'b0, 1'b0, 32'h80, 32'h0);
        checkOutput("r_ack",        32'(o_host_ack),   32'h1);
        checkOutput("r_rdata",      o_host_rdata,      32'h12345678);
        nextCycle();
        checkOutput("r_after_ack",  32'(o_host_ack),   32'h0);
        checkOutput("r_rdata_hold", o_host_rdata,      32'h12345678);

        // Contention: CPU wins 8 HOST_ACC cycles, host forced on the 9th with one stall
        applyStimulus(1'b1, 1'b0, 32'h200, 1'b1, 1'b1, 32'h44, 32'hCAFEF00D);
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("c_cpu_adr%0d", i),   o_mem_adr,         32'h200);
            checkOutput($sformatf("c_cpu_stall%0d", i), 32'(o_cpu_stall),  32'h0);
            checkOutput($sformatf("c_cpu_ack%0d", i),   32'(o_host_ack),   32'h0);
            nextCycle();
        end
        checkOutput("c_grant_stall", 32'(o_cpu_stall), 32'h1);
        checkOutput("c_grant_adr",   o_mem_adr,         32'h44);
        checkOutput("c_grant_wdata", o_mem_wdata,       32'hCAFEF00D);
        checkOutput("c_grant_we",    32'(o_mem_we),     32'h1);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D);
        checkOutput("c_ack",        32'(o_host_ack),   32'h1);
        checkOutput("c_ack_stall",  32'(o_cpu_stall),  32'h0);
        checkOutput("c_ack_adr",    o_mem_adr,         32'h200);
        nextCycle();
        checkOutput("c_after_ack",  32'(o_host_ack),   32'h0);
        checkOutput("c_after_stall",32'(o_cpu_stall),  32'h0);

        // CPU frees the port after 3 HOST_ACC cycles
        applyStimulus(1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h48, 32'h0BADF00D);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("e_cpu_adr%0d", i),   o_mem_adr,        32'h300);
            checkOutput($sformatf("e_cpu_stall%0d", i), 32'(o_cpu_stall), 32'h0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h300, 1'b1, 1'b1, 32'h48, 32'h0BADF00D);
        checkOutput("e_grant_adr",   o_mem_adr,         32'h48);
        checkOutput("e_grant_we",    32'(o_mem_we),     32'h1);
        checkOutput("e_grant_stall", 32'(o_cpu_stall),  32'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'h300, 1'b0, 1'b1, 32'h48, 32'h0BADF00D);
        checkOutput("e_ack",        32'(o_host_ack),   32'h1);
        checkOutput("e_rdata",      o_host_rdata,      32'hA5A50048);
`ifdef ARB_PERF_EN
        checkOutput("perf_grants",  32'(o_perf_host_grants), 32'h4);
        checkOutput("perf_stalls",  32'(o_perf_cpu_stalls),  32'h1);
`endif
        nextCycle();

        // Abort under contention: no host access, no ack
        applyStimulus(1'b1, 1'b0, 32'h400, 1'b1, 1'b1, 32'h4C, 32'h77777777);
        nextCycle();
        checkOutput("a_cpu_adr0",   o_mem_adr,         32'h400);
        nextCycle();
        checkOutput("a_cpu_adr1",   o_mem_adr,         32'h400);
        applyStimulus(1'b1, 1'b0, 32'h400, 1'b0, 1'b1, 32'h4C, 32'h77777777);
        checkOutput("a_drop_adr",   o_mem_adr,         32'h400);
        checkOutput("a_drop_stall", 32'(o_cpu_stall),  32'h0);
        nextCycle();
        checkOutput("a_idle_ack",   32'(o_host_ack),   32'h0);
        checkOutput("a_idle_adr",   o_mem_adr,         32'h400);
        nextCycle();
        checkOutput("a_late_ack",   32'(o_host_ack),   32'h0);

        // Reset while a contended host write is waiting in HOST_ACC
        applyStimulus(1'b1, 1'b0, 32'h500, 1'b1, 1'b1, 32'h50, 32'h99999999);
        nextCycle();
        nextCycle();
        i_reset = 1'b1;
        nextCycle();
        i_reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 32'h50, 32'h99999999);
        checkOutput("x_ack",        32'(o_host_ack),   32'h0);
        checkOutput("x_rdata",      o_host_rdata,      32'h0);
        checkOutput("x_adr",        o_mem_adr,         32'h500);
        checkOutput("x_stall",      32'(o_cpu_stall),  32'h0);
`ifdef ARB_PERF_EN
        checkOutput("x_perf_g",     32'(o_perf_host_grants), 32'h0);
        checkOutput("x_perf_s",     32'(o_perf_cpu_stalls),  32'h0);
`endif
        nextCycle();
        checkOutput("x_after_ack",  32'(o_host_ack),   32'h0);
        checkOutput("x_after_adr",  o_mem_adr,         32'h500);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
